// File: rtl/ct_stream_loader.sv
// Serial-to-parallel loader that assembles two ciphertexts (A/B vectors of N slots each) for ct_ct_add.
// Optional coefficient range check against Q is enabled by defining CT_LOADER_RANGE_CHECK_EN.
`ifndef W_BITS
`define W_BITS 16
`endif
`ifndef Q_MOD
`define Q_MOD 7710
`endif

module ct_stream_loader #(
  parameter int N = 8,
  parameter int W = `W_BITS,
  parameter int Q = `Q_MOD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [W-1:0]              s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [1:0][N-1:0][W-1:0]  m_ct1,
  output logic [1:0][N-1:0][W-1:0]  m_ct2,
  output logic                      frame_err,
  output logic                      range_err
);

  localparam int FRAME = 4 * N;
  localparam int IW    = $clog2(FRAME);
  localparam int SLW   = $clog2(N);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            last_idx;
  logic            xfer;
  logic            store;
  logic            sel_ct;
  logic            sel_vec;
  logic [SLW-1:0]  slot;

  // Handshake flags come straight from the state register, no input feedthrough.
  assign s_ready  = (state == FILL);
  assign m_valid  = (state == FULL);

  assign last_idx = (idx == IW'(FRAME - 1));
  assign xfer     = s_valid && (state == FILL);
  // A word is kept only when s_last agrees with the frame position; any mismatch is a framing error.
  assign store    = xfer && (last_idx == s_last);

  // idx layout: [msb] = ct1/ct2, [msb-1] = A/B (vector index 0 = A, 1 = B), low bits = slot.
  assign sel_ct   = idx[IW-1];
  assign sel_vec  = idx[IW-2];
  assign slot     = idx[SLW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      m_ct1     <= '0;
      m_ct2     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == FULL) begin
        if (m_ready) state <= FILL;
      end else if (xfer) begin
        if (store) begin
          if (sel_ct) m_ct2[sel_vec][slot] <= s_data;
          else        m_ct1[sel_vec][slot] <= s_data;
          if (last_idx) begin
            idx   <= '0;
            state <= FULL;
          end else begin
            idx   <= idx + 1'b1;
          end
        end else begin
          // Early or missing s_last: drop the word and resynchronise to a fresh frame.
          frame_err <= 1'b1;
          idx       <= '0;
        end
      end
    end
  end

`ifdef CT_LOADER_RANGE_CHECK_EN
  localparam logic [W:0] Q_EXT = (W+1)'(Q);

  function automatic logic out_of_range(input logic [W-1:0] d);
    return ({1'b0, d} >= Q_EXT);
  endfunction

  // Sticky until reset; discarded words never raise it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (store && out_of_range(s_data)) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule
